// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one combinational-read instruction ROM between the IF and MEM
// requesters, with MEM priority, an IF starvation guard and registered responses.
`timescale 1ns/1ps
`default_nettype none

module rom_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int ROM_BYTES  = 512,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  output logic              if_err,

  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  output logic              mem_gnt,
  output logic              mem_rvalid,
  output logic [31:0]       mem_rdata,
  output logic              mem_err,

  input  logic              flush,

  output logic              rom_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_inst,

  output logic              stall_req
);

  localparam logic [ADDR_W-1:0] MAX_ADDR   = ADDR_W'(ROM_BYTES - 4);
  localparam logic [3:0]        STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [0:0] {
    PRI_MEM = 1'b0,
    PRI_IF  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  starve_q, starve_d;

  logic        if_rvalid_q, if_rvalid_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        if_err_q, if_err_d;
  logic        mem_rvalid_q, mem_rvalid_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        mem_err_q, mem_err_d;

  logic        if_legal, mem_legal;
  logic        if_ill, mem_ill;
  logic        if_lreq, mem_lreq;
  logic        if_rom, mem_rom;

  // Illegal requests bypass arbitration: they are granted at once and never touch the ROM.
  always_comb begin
    if_legal  = (if_addr[1:0] == 2'b00) && (if_addr <= MAX_ADDR);
    mem_legal = (mem_addr[1:0] == 2'b00) && (mem_addr <= MAX_ADDR);
    if_ill    = if_req & ~if_legal;
    mem_ill   = mem_req & ~mem_legal;
    if_lreq   = if_req & if_legal;
    mem_lreq  = mem_req & mem_legal;
  end

  always_comb begin
    if_rom  = 1'b0;
    mem_rom = 1'b0;
    if (if_lreq && mem_lreq) begin
      if (state_q == PRI_IF) begin
        if_rom = 1'b1;
      end else begin
        mem_rom = 1'b1;
      end
    end else begin
      if_rom  = if_lreq;
      mem_rom = mem_lreq;
    end
  end

  always_comb begin
    if_gnt    = if_ill | if_rom;
    mem_gnt   = mem_ill | mem_rom;
    rom_en    = if_rom | mem_rom;
    rom_addr  = '0;
    if (if_rom) begin
      rom_addr = if_addr;
    end else if (mem_rom) begin
      rom_addr = mem_addr;
    end
    stall_req = (if_req & ~if_gnt) | (mem_req & ~mem_gnt);
  end

  // Priority flips as soon as the next counter value hits the limit, so IF wins the
  // cycle right after its STARVE_MAX-th denial.
  always_comb begin
    starve_d = '0;
    if (if_req && !if_gnt) begin
      starve_d = (starve_q >= STARVE_LIM) ? STARVE_LIM : starve_q + 4'd1;
    end

    state_d = state_q;
    case (state_q)
      PRI_MEM: if (starve_d == STARVE_LIM) state_d = PRI_IF;
      PRI_IF:  if (if_gnt || !if_req)      state_d = PRI_MEM;
      default: state_d = PRI_MEM;
    endcase
  end

  // A flushed IF grant produces no pulse and leaves the previous data/err intact.
  always_comb begin
    if_rvalid_d = if_gnt & ~flush;
    if_rdata_d  = if_rdata_q;
    if_err_d    = if_err_q;
    if (if_gnt && !flush) begin
      if_rdata_d = if_ill ? 32'h0 : rom_inst;
      if_err_d   = if_ill;
    end

    mem_rvalid_d = mem_gnt;
    mem_rdata_d  = mem_rdata_q;
    mem_err_d    = mem_err_q;
    if (mem_gnt) begin
      mem_rdata_d = mem_ill ? 32'h0 : rom_inst;
      mem_err_d   = mem_ill;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= PRI_MEM;
      starve_q     <= '0;
      if_rvalid_q  <= 1'b0;
      if_rdata_q   <= '0;
      if_err_q     <= 1'b0;
      mem_rvalid_q <= 1'b0;
      mem_rdata_q  <= '0;
      mem_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      if_rvalid_q  <= if_rvalid_d;
      if_rdata_q   <= if_rdata_d;
      if_err_q     <= if_err_d;
      mem_rvalid_q <= mem_rvalid_d;
      mem_rdata_q  <= mem_rdata_d;
      mem_err_q    <= mem_err_d;
    end
  end

  assign if_rvalid  = if_rvalid_q;
  assign if_rdata   = if_rdata_q;
  assign if_err     = if_err_q;
  assign mem_rvalid = mem_rvalid_q;
  assign mem_rdata  = mem_rdata_q;
  assign mem_err    = mem_err_q;

endmodule

`default_nettype wire

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed self-checking bench for rom_arbiter with a byte-array ROM model.
`timescale 1ns/1ps
`default_nettype none

module tb_rom_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        mem_err;
  logic        flush;
  logic        rom_en;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        stall_req;

  int nchecks = 0;
  int nerr    = 0;

  logic [7:0] rom_b [0:511];
  logic [8:0] ra;

  assign ra       = rom_addr[8:0];
  assign rom_inst = rom_en ? {rom_b[ra], rom_b[ra + 9'd1], rom_b[ra + 9'd2], rom_b[ra + 9'd3]} : 32'h0;

  rom_arbiter #(.ADDR_W(32), .ROM_BYTES(512), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .flush(flush), .rom_en(rom_en), .rom_addr(rom_addr), .rom_inst(rom_inst),
    .stall_req(stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    #2;
    nchecks++; if (if_rvalid !== 1'b0) begin nerr++; $display("FAIL rst_if_rvalid got=%b exp=0", if_rvalid); end
    nchecks++; if (if_rdata !== 32'h0) begin nerr++; $display("FAIL rst_if_rdata got=%h exp=0", if_rdata); end
    nchecks++; if (mem_rvalid !== 1'b0) begin nerr++; $display("FAIL rst_mem_rvalid got=%b exp=0", mem_rvalid); end
    nchecks++; if (mem_err !== 1'b0 || if_err !== 1'b0) begin nerr++; $display("FAIL rst_err got=%b%b exp=00", if_err, mem_err); end
    @(posedge clk); #1;
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h08;
    #1;
    nchecks++; if (if_gnt !== 1'b1) begin nerr++; $display("FAIL rst_pre_gnt got=%b exp=1", if_gnt); end
    @(posedge clk); #1;
    nchecks++; if (if_rvalid !== 1'b1) begin nerr++; $display("FAIL rst_pre_rvalid got=%b exp=1", if_rvalid); end
    // IF still requesting and granted; reset hits mid-cycle.
    #1 rst = 1'b0;
    #1;
    nchecks++; if (if_rvalid !== 1'b0) begin nerr++; $display("FAIL rst_async_rvalid got=%b exp=0", if_rvalid); end
    nchecks++; if (if_rdata !== 32'h0) begin nerr++; $display("FAIL rst_async_rdata got=%h exp=0", if_rdata); end
    if_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    nchecks++; if (if_rvalid !== 1'b0) begin nerr++; $display("FAIL rst_post_rvalid got=%b exp=0", if_rvalid); end
    if_req = 1'b1; if_addr = 32'h10; mem_req = 1'b1; mem_addr = 32'h20;
    #1;
    nchecks++; if (mem_gnt !== 1'b1 || if_gnt !== 1'b0) begin nerr++; $display("FAIL rst_pri_mem got=%b%b exp=10", mem_gnt, if_gnt); end
    if_req = 1'b0; mem_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_if_alone();
    if_req = 1'b1; if_addr = 32'h08;
    #1;
    nchecks++; if (if_gnt !== 1'b1) begin nerr++; $display("FAIL ifa_gnt got=%b exp=1", if_gnt); end
    nchecks++; if (rom_en !== 1'b1 || rom_addr !== 32'h08) begin nerr++; $display("FAIL ifa_rom got=%b/%h exp=1/00000008", rom_en, rom_addr); end
    nchecks++; if (stall_req !== 1'b0) begin nerr++; $display("FAIL ifa_stall got=%b exp=0", stall_req); end
    @(posedge clk); #1;
    if_req = 1'b0;
    nchecks++; if (if_rvalid !== 1'b1) begin nerr++; $display("FAIL ifa_rvalid got=%b exp=1", if_rvalid); end
    nchecks++; if (if_rdata !== 32'h3c010012) begin nerr++; $display("FAIL ifa_rdata got=%h exp=3c010012", if_rdata); end
    nchecks++; if (if_err !== 1'b0) begin nerr++; $display("FAIL ifa_err got=%b exp=0", if_err); end
    #1;
    nchecks++; if (rom_en !== 1'b0 || rom_addr !== 32'h0) begin nerr++; $display("FAIL ifa_idle_rom got=%b/%h exp=0/0", rom_en, rom_addr); end
    @(posedge clk); #1;
    nchecks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h3c010012) begin nerr++; $display("FAIL ifa_hold got=%b/%h exp=0/3c010012", if_rvalid, if_rdata); end
  endtask

  task automatic test_starvation();
    if_req = 1'b1; if_addr = 32'h10; mem_req = 1'b1; mem_addr = 32'h20;
    for (int c = 1; c <= 6; c++) begin
      #1;
      if (c <= 4) begin
        nchecks++; if (mem_gnt !== 1'b1 || if_gnt !== 1'b0 || stall_req !== 1'b1) begin nerr++; $display("FAIL starve_c%0d got mem_gnt=%b if_gnt=%b stall=%b exp=1/0/1", c, mem_gnt, if_gnt, stall_req); end
      end else if (c == 5) begin
        nchecks++; if (if_gnt !== 1'b1 || mem_gnt !== 1'b0 || rom_addr !== 32'h10) begin nerr++; $display("FAIL starve_c5 got if_gnt=%b mem_gnt=%b addr=%h exp=1/0/10", if_gnt, mem_gnt, rom_addr); end
      end else begin
        nchecks++; if (mem_gnt !== 1'b1 || if_gnt !== 1'b0) begin nerr++; $display("FAIL starve_c6 got mem_gnt=%b if_gnt=%b exp=1/0", mem_gnt, if_gnt); end
        nchecks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h11223344) begin nerr++; $display("FAIL starve_if_resp got=%b/%h exp=1/11223344", if_rvalid, if_rdata); end
      end
      if (c == 2) begin
        nchecks++; if (mem_rvalid !== 1'b1 || mem_rdata !== 32'haabbccdd) begin nerr++; $display("FAIL starve_mem_resp got=%b/%h exp=1/aabbccdd", mem_rvalid, mem_rdata); end
      end
      if (c < 6) begin
        @(posedge clk); #1;
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned();
    if_req = 1'b1; if_addr = 32'h06; mem_req = 1'b1; mem_addr = 32'h10;
    #1;
    nchecks++; if (if_gnt !== 1'b1 || mem_gnt !== 1'b1) begin nerr++; $display("FAIL mis_gnt got=%b%b exp=11", if_gnt, mem_gnt); end
    nchecks++; if (rom_en !== 1'b1 || rom_addr !== 32'h10) begin nerr++; $display("FAIL mis_rom got=%b/%h exp=1/10", rom_en, rom_addr); end
    @(posedge clk); #1;
    if_req = 1'b0; mem_req = 1'b0;
    nchecks++; if (if_rvalid !== 1'b1 || if_err !== 1'b1 || if_rdata !== 32'h0) begin nerr++; $display("FAIL mis_if_resp got=%b/%b/%h exp=1/1/0", if_rvalid, if_err, if_rdata); end
    nchecks++; if (mem_rvalid !== 1'b1 || mem_err !== 1'b0 || mem_rdata !== 32'h11223344) begin nerr++; $display("FAIL mis_mem_resp got=%b/%b/%h exp=1/0/11223344", mem_rvalid, mem_err, mem_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_bounds();
    mem_req = 1'b1; mem_addr = 32'h1FC;
    #1;
    nchecks++; if (mem_gnt !== 1'b1 || rom_en !== 1'b1) begin nerr++; $display("FAIL bnd_top_gnt got=%b/%b exp=1/1", mem_gnt, rom_en); end
    @(posedge clk); #1;
    mem_addr = 32'h200;
    nchecks++; if (mem_rvalid !== 1'b1 || mem_err !== 1'b0 || mem_rdata !== 32'hdeadbeef) begin nerr++; $display("FAIL bnd_top_resp got=%b/%b/%h exp=1/0/deadbeef", mem_rvalid, mem_err, mem_rdata); end
    #1;
    nchecks++; if (mem_gnt !== 1'b1 || rom_en !== 1'b0 || rom_addr !== 32'h0) begin nerr++; $display("FAIL bnd_over_gnt got=%b/%b/%h exp=1/0/0", mem_gnt, rom_en, rom_addr); end
    @(posedge clk); #1;
    nchecks++; if (mem_rvalid !== 1'b1 || mem_err !== 1'b1 || mem_rdata !== 32'h0) begin nerr++; $display("FAIL bnd_over_resp got=%b/%b/%h exp=1/1/0", mem_rvalid, mem_err, mem_rdata); end
    if_req = 1'b1; if_addr = 32'h201; mem_addr = 32'h202;
    #1;
    nchecks++; if (if_gnt !== 1'b1 || mem_gnt !== 1'b1 || rom_en !== 1'b0 || stall_req !== 1'b0) begin nerr++; $display("FAIL bnd_both_ill got=%b%b en=%b stall=%b exp=11/0/0", if_gnt, mem_gnt, rom_en, stall_req); end
    @(posedge clk); #1;
    if_req = 1'b0; mem_req = 1'b0;
    nchecks++; if (if_err !== 1'b1 || mem_err !== 1'b1 || if_rvalid !== 1'b1) begin nerr++; $display("FAIL bnd_both_resp got=%b%b v=%b exp=11/1", if_err, mem_err, if_rvalid); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush();
    if_req = 1'b1; if_addr = 32'h08; flush = 1'b0;
    @(posedge clk); #1;
    if_addr = 32'h10; flush = 1'b1;
    nchecks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h3c010012) begin nerr++; $display("FAIL fl_noflush got=%b/%h exp=1/3c010012", if_rvalid, if_rdata); end
    #1;
    nchecks++; if (if_gnt !== 1'b1) begin nerr++; $display("FAIL fl_gnt got=%b exp=1", if_gnt); end
    @(posedge clk); #1;
    if_req = 1'b0; mem_req = 1'b1; mem_addr = 32'h20;
    nchecks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h3c010012 || if_err !== 1'b0) begin nerr++; $display("FAIL fl_flushed got=%b/%h/%b exp=0/3c010012/0", if_rvalid, if_rdata, if_err); end
    @(posedge clk); #1;
    mem_req = 1'b0; flush = 1'b0;
    nchecks++; if (mem_rvalid !== 1'b1 || mem_rdata !== 32'haabbccdd) begin nerr++; $display("FAIL fl_mem got=%b/%h exp=1/aabbccdd", mem_rvalid, mem_rdata); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    if_req = 1'b1; if_addr = 32'h08;
    @(posedge clk); #1;
    if_addr = 32'h20;
    nchecks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h3c010012) begin nerr++; $display("FAIL b2b_first got=%b/%h exp=1/3c010012", if_rvalid, if_rdata); end
    @(posedge clk); #1;
    if_req = 1'b0;
    nchecks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'haabbccdd) begin nerr++; $display("FAIL b2b_second got=%b/%h exp=1/aabbccdd", if_rvalid, if_rdata); end
    @(posedge clk); #1;
    nchecks++; if (if_rvalid !== 1'b0) begin nerr++; $display("FAIL b2b_end got=%b exp=0", if_rvalid); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom_b[i] = 8'(i) ^ 8'h5A;
    {rom_b[8],   rom_b[9],   rom_b[10],  rom_b[11]}  = 32'h3c010012;
    {rom_b[16],  rom_b[17],  rom_b[18],  rom_b[19]}  = 32'h11223344;
    {rom_b[32],  rom_b[33],  rom_b[34],  rom_b[35]}  = 32'haabbccdd;
    {rom_b[508], rom_b[509], rom_b[510], rom_b[511]} = 32'hdeadbeef;
    rst = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_addr = '0; flush = 1'b0;

    test_reset();
    test_if_alone();
    test_starvation();
    test_misaligned();
    test_bounds();
    test_flush();
    test_back_to_back();

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single combinational-read instruction ROM between two requesters: the instruction-fetch stage (IF) and the memory stage (MEM), which issues constant loads from the code region.
- Drives the ROM's en/addr pins and arbitrates per cycle, MEM having priority by default.
- A starvation guard forces IF priority after repeated denials.
- Registers the returned big-endian word into per-requester response registers, one cycle after grant.

Parameters:
- ADDR_W, 32, width of byte addresses on all address ports.
- ROM_BYTES, 512, ROM size in bytes; highest legal word address is ROM_BYTES-4.
- STARVE_MAX, 4, consecutive IF denials that force IF priority (range 1..15).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- if_req  in  1  IF request; held high with stable if_addr until if_gnt.
- if_addr  in  ADDR_W  IF byte address.
- if_gnt  out  1  combinational; request accepted this cycle.
- if_rvalid  out  1  registered; response valid, 1-cycle pulse.
- if_rdata  out  32  registered; fetched word, held until next if_rvalid.
- if_err  out  1  registered; qualifies if_rvalid, address illegal.
- mem_req  in  1  MEM request (same rules as if_req).
- mem_addr  in  ADDR_W  MEM byte address.
- mem_gnt  out  1  combinational grant.
- mem_rvalid  out  1  registered response pulse.
- mem_rdata  out  32  registered word, held.
- mem_err  out  1  registered error flag.
- flush  in  1  cancels the IF response of an IF grant in the same cycle.
- rom_en  out  1  combinational ROM enable.
- rom_addr  out  ADDR_W  combinational ROM byte address; 0 when rom_en=0.
- rom_inst  in  32  ROM word, combinational from rom_en/rom_addr.
- stall_req  out  1  combinational pipeline stall request.

Behaviour:
- Reset (rst=0, async, any time, including mid-transaction):
  - all registered outputs 0; state PRI_MEM; starve counter 0.
  - No response is produced for a grant in the cycle reset asserts.
- Legality: an address is illegal if addr[1:0]!=0 or addr > ROM_BYTES-4. Otherwise it is legal.
- Illegal requests:
  - granted immediately in the same cycle, independent of arbitration.
  - never drive rom_en.
  - next cycle: rvalid=1, err=1, rdata=0.
- Legal requests compete for the ROM.
  - State PRI_MEM: MEM wins if both are legal and requesting.
  - State PRI_IF: IF wins.
  - A lone legal requester always wins.
- Winner: gnt=1, rom_en=1, rom_addr=winner addr.
  - Next cycle: rvalid=1, err=0, rdata=rom_inst captured at the grant edge.
- Loser: gnt=0 and must hold request/address.
- If neither requester is granted a ROM access: rom_en=0, rom_addr=0.
- Starve counter (4 bits):
  - increments on each cycle with if_req=1 and if_gnt=0.
  - clears on if_gnt=1 or if_req=0.
  - saturates at STARVE_MAX.
- FSM transitions:
  - PRI_MEM -> PRI_IF when the counter reaches STARVE_MAX (registered; effective the following cycle).
  - PRI_IF -> PRI_MEM on the cycle after any if_gnt, or if if_req drops.
- Flush:
  - flush=1 in a cycle with if_gnt=1: next-cycle if_rvalid=0; if_rdata and if_err unchanged.
  - flush has no effect on MEM or on cycles without if_gnt.
- Response timing: latency is exactly 1 cycle from grant to rvalid.
  - A requester granted on consecutive cycles gets back-to-back rvalid pulses.
  - No response buffering beyond one register per port.
- stall_req = (if_req & ~if_gnt) | (mem_req & ~mem_gnt).
- Simultaneous case: both requests illegal → both granted the same cycle, rom_en=0.

Test Plan:
- Reset: assert rst=0 while an IF grant is in flight -> all outputs 0 immediately; no if_rvalid after release; state PRI_MEM.
- IF alone, if_addr=0x08, ROM bytes 8..11 = 3c,01,00,12 -> if_gnt=1, rom_addr=0x08 same cycle; next cycle if_rvalid=1, if_rdata=0x3c010012, if_err=0.
- Both legal (if 0x10, mem 0x20) held continuously, STARVE_MAX=4:
  - cycles 1-4: mem_gnt=1, if_gnt=0, stall_req=1.
  - cycle 5: if_gnt=1, rom_addr=0x10.
  - cycle 6: mem wins again.
- if_addr=0x06 (misaligned) with mem_addr=0x10 -> both gnt same cycle, rom_addr=0x10; next cycle if_err=1, if_rdata=0, mem_rvalid=1 with word at 0x10.
- Bounds: mem_addr=0x1FC -> err=0, valid data; mem_addr=0x200 -> err=1, rdata=0, rom_en=0.
- IF granted with flush=1 -> next cycle if_rvalid=0, if_rdata keeps previous value; same with flush=0 -> if_rvalid=1.
